// File: rtl/fall_rate_scheduler.sv
// Level-dependent, pausable fall-strobe scheduler: divides clk into a base tick
// and emits a one-cycle fall_pulse every E ticks, E set by level and fast_drop.
module fall_rate_scheduler #(
  parameter int FREQ_CLK    = 50000000,
  parameter int FREQ_TICK   = 1000,
  parameter int BASE_PERIOD = 500,
  parameter int STEP        = 40,
  parameter int MIN_PERIOD  = 100,
  parameter int FAST_PERIOD = 50,
  parameter int LEVEL_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               fast_drop,
  input  logic [LEVEL_W-1:0] level,
  output logic               fall_pulse,
  output logic               running,
  output logic               paused,
  output logic [7:0]         fall_count
);

  localparam int DIV = FREQ_CLK / FREQ_TICK;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0] DIV_M1    = PW'(DIV - 1);
  localparam logic [31:0]   BASE_U    = 32'(BASE_PERIOD);
  localparam logic [31:0]   MIN_U     = 32'(MIN_PERIOD);
  localparam logic [31:0]   FAST_U    = 32'(FAST_PERIOD);
  localparam logic [31:0]   HEADROOM  = 32'(BASE_PERIOD - MIN_PERIOD);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          pulse_q, pulse_d;
  logic [7:0]    count_q, count_d;

  logic [31:0] level_step;
  logic [31:0] level_period;
  logic [31:0] eff_period;
  logic        tick;

  // Compare before subtracting so a high level can never underflow the period.
  always_comb begin
    level_step   = 32'(level) * 32'(STEP);
    level_period = (level_step >= HEADROOM) ? MIN_U : (BASE_U - level_step);
    eff_period   = (fast_drop && (FAST_U < level_period)) ? FAST_U : level_period;
  end

  assign tick = (state_q == RUN) && (presc_q == DIV_M1);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    count_d = count_q;

    case (state_q)
      IDLE: begin
        presc_d = '0;
        cnt_d   = '0;
        if (start) begin
          state_d = RUN;
          count_d = '0;
        end
      end
      RUN: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) begin
          // >= lets a mid-count period decrease fire on the very next tick.
          if ({16'd0, cnt_q} >= (eff_period - 32'd1)) begin
            cnt_d   = '0;
            pulse_d = 1'b1;
            count_d = count_q + 8'd1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        if (pause) state_d = PAUSED;
      end
      PAUSED: begin
        if (!pause) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase

    if (stop) begin
      state_d = IDLE;
      presc_d = '0;
      cnt_d   = '0;
      pulse_d = 1'b0;
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      count_q <= count_d;
    end
  end

  assign fall_pulse = pulse_q;
  assign running    = (state_q == RUN);
  assign paused     = (state_q == PAUSED);
  assign fall_count = count_q;

endmodule

// File: tb/tb_fall_rate_scheduler.sv
// Bench for fall_rate_scheduler: directed test-plan steps plus a random phase,
// all checked each cycle against a tick-counting reference model.
module tb_fall_rate_scheduler;

  localparam int DIV   = 10;
  localparam int BASE  = 8;
  localparam int STP   = 2;
  localparam int MINP  = 2;
  localparam int FASTP = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       fast_drop = 1'b0;
  logic [3:0] level = 4'd0;
  logic       fall_pulse;
  logic       running;
  logic       paused;
  logic [7:0] fall_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;

  // Reference model: 0 idle, 1 run, 2 paused; run_edges counts RUN edges since start.
  int m_state, m_run_edges, m_since, m_count;
  bit m_pulse;
  bit prev_pulse;

  always #5 clk = ~clk;

  fall_rate_scheduler #(
    .FREQ_CLK(100), .FREQ_TICK(10), .BASE_PERIOD(BASE), .STEP(STP),
    .MIN_PERIOD(MINP), .FAST_PERIOD(FASTP), .LEVEL_W(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .fast_drop(fast_drop), .level(level), .fall_pulse(fall_pulse),
    .running(running), .paused(paused), .fall_count(fall_count)
  );

  function automatic int eff_period(int lvl, bit fd);
    int p;
    p = BASE - lvl * STP;
    if (p < MINP) p = MINP;
    if (fd && FASTP < p) p = FASTP;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_run_edges = 0; m_since = 0; m_count = 0; m_pulse = 0;
  endtask

  task automatic model_edge();
    int  e;
    bit  tk;
    e = eff_period(int'(level), fast_drop);
    prev_pulse = m_pulse;
    m_pulse = 0;
    if (!reset) begin
      model_reset();
    end else if (stop) begin
      m_state = 0; m_run_edges = 0; m_since = 0;
    end else begin
      case (m_state)
        0: if (start) begin
             m_state = 1; m_run_edges = 0; m_since = 0; m_count = 0; start_cyc = cyc;
           end
        1: begin
             tk = (m_run_edges % DIV) == DIV - 1;
             m_run_edges++;
             if (tk) begin
               if (m_since + 1 >= e) begin
                 m_pulse = 1; m_since = 0; m_count = (m_count + 1) % 256;
               end else begin
                 m_since++;
               end
             end
             if (pause) m_state = 2;
           end
        default: if (!pause) m_state = 1;
      endcase
    end
  endtask

  task automatic compare_all();
    chk("model_pulse", {31'd0, fall_pulse}, {31'd0, m_pulse});
    chk("model_running", {31'd0, running}, (m_state == 1) ? 32'd1 : 32'd0);
    chk("model_paused", {31'd0, paused}, (m_state == 2) ? 32'd1 : 32'd0);
    chk("model_count", {24'd0, fall_count}, 32'(m_count));
    if (prev_pulse) chk("no_double_pulse", {31'd0, fall_pulse}, 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
  endtask

  task automatic run_until_pulse(input int limit, input string tag, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      step();
      if (fall_pulse === 1'b1) begin
        at = cyc;
        break;
      end
    end
    checks++;
    assert (at >= 0) else begin
      errors++;
      $error("FAIL %s_timeout observed=no_pulse expected=pulse_within_%0d", tag, limit);
    end
  endtask

  initial begin
    int k, at, prev;
    int lv[3];
    lv[0] = 3; lv[1] = 5; lv[2] = 15;
    model_reset();
    prev_pulse = 0;

    // Reset state
    #2;
    chk("reset_pulse", {31'd0, fall_pulse}, 32'd0);
    chk("reset_running", {31'd0, running}, 32'd0);
    chk("reset_paused", {31'd0, paused}, 32'd0);
    chk("reset_count", {24'd0, fall_count}, 32'd0);
    #10 reset = 1'b1;
    step();

    // Level 0: pulses at k+80, k+160, k+240
    level = 4'd0;
    do_start();
    k = start_cyc;
    chk("lvl0_start_cyc", 32'(cyc), 32'(k));
    run_until_pulse(100, "lvl0_p1", at); chk("lvl0_p1_off", 32'(at - k), 32'd80);
    run_until_pulse(100, "lvl0_p2", at); chk("lvl0_p2_off", 32'(at - k), 32'd160);
    run_until_pulse(100, "lvl0_p3", at); chk("lvl0_p3_off", 32'(at - k), 32'd240);
    chk("lvl0_count", {24'd0, fall_count}, 32'd3);
    do_stop();

    // Period floor
    for (int i = 0; i < 3; i++) begin
      level = 4'(lv[i]);
      do_start();
      k = cyc;
      run_until_pulse(40, "floor_p1", at); chk("floor_first_off", 32'(at - k), 32'd20);
      prev = at;
      run_until_pulse(40, "floor_p2", at); chk("floor_interval", 32'(at - prev), 32'd20);
      do_stop();
    end

    // Fast drop raised at cnt=5
    level = 4'd0;
    do_start();
    k = cyc;
    repeat (52) step();
    fast_drop = 1'b1;
    run_until_pulse(20, "fast_p1", at); chk("fast_first_off", 32'(at - k), 32'd60);
    prev = at;
    run_until_pulse(20, "fast_p2", at); chk("fast_interval", 32'(at - prev), 32'd10);
    prev = at;
    fast_drop = 1'b0;
    run_until_pulse(100, "slow_again", at); chk("slow_interval", 32'(at - prev), 32'd80);
    do_stop();

    // Pause for 37 cycles mid-period
    do_start();
    run_until_pulse(100, "pause_p1", prev);
    repeat (20) step();
    pause = 1'b1;
    repeat (37) step();
    chk("pause_paused", {31'd0, paused}, 32'd1);
    chk("pause_count_held", {24'd0, fall_count}, 32'd1);
    pause = 1'b0;
    run_until_pulse(200, "pause_p2", at); chk("pause_delay", 32'(at - prev), 32'd117);
    do_stop();

    // Stop and start together in IDLE
    start = 1'b1; stop = 1'b1;
    step();
    chk("stop_start_idle", {31'd0, running}, 32'd0);
    start = 1'b0; stop = 1'b0;

    // Stop on the tick edge that would pulse
    do_start();
    repeat (79) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_tick_pulse", {31'd0, fall_pulse}, 32'd0);
    chk("stop_tick_running", {31'd0, running}, 32'd0);
    chk("stop_tick_count", {24'd0, fall_count}, 32'd0);
    repeat (5) step();
    chk("stop_stays_idle", {31'd0, running}, 32'd0);
    do_start();
    k = cyc;
    run_until_pulse(100, "after_stop", at); chk("after_stop_off", 32'(at - k), 32'd80);

    // Asynchronous reset mid-count
    repeat (33) step();
    #2 reset = 1'b0;
    #1;
    model_reset();
    prev_pulse = 0;
    chk("areset_pulse", {31'd0, fall_pulse}, 32'd0);
    chk("areset_running", {31'd0, running}, 32'd0);
    chk("areset_paused", {31'd0, paused}, 32'd0);
    chk("areset_count", {24'd0, fall_count}, 32'd0);
    #2 reset = 1'b1;
    repeat (15) step();
    chk("areset_idle", {31'd0, running}, 32'd0);

    // Randomized operation against the model
    do_start();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(49) == 0) level = 4'($urandom_range(15));
      if ($urandom_range(59) == 0) fast_drop = ~fast_drop;
      if ($urandom_range(39) == 0) pause = ~pause;
      stop  = ($urandom_range(299) == 0);
      start = ($urandom_range(19) == 0);
      step();
    end
    start = 1'b0; stop = 1'b0; pause = 1'b0;
    do_stop();

    // Wrap: 256 pulses at E=1
    level = 4'd15; fast_drop = 1'b1;
    do_start();
    repeat (2560) step();
    chk("wrap_pulse", {31'd0, fall_pulse}, 32'd1);
    chk("wrap_count", {24'd0, fall_count}, 32'd0);
    do_stop();
    level = 4'd0; fast_drop = 1'b0;
    do_start();
    k = cyc;
    chk("restart_count", {24'd0, fall_count}, 32'd0);
    run_until_pulse(100, "restart_p1", at); chk("restart_off", 32'(at - k), 32'd80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
